// File: rtl/imem_arb_pkg.sv
// rtl/imem_arb_pkg.sv - shared state encoding and default sizing for the instruction-memory arbiter
package imem_arb_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    PATCH = 2'd2
  } arb_state_e;

  localparam int DEF_ADDR_W    = 10;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_MAX_BURST = 16;
  localparam int DEF_RUN_MIN   = 4;

endpackage

// File: rtl/imem_arbiter_if.sv
// rtl/imem_arbiter_if.sv - fetch, loader and memory-side bundle between the arbiter and its neighbours
interface imem_arbiter_if
  import imem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_rdata;
  logic              cpu_stall;

  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_done;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // slave = arbiter; master = core, loader and memory array around it
  modport slave (
    input  fetch_req, fetch_addr, ld_valid, ld_addr, ld_data, ld_done, mem_rdata,
    output fetch_valid, fetch_rdata, cpu_stall, ld_ready,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output fetch_req, fetch_addr, ld_valid, ld_addr, ld_data, ld_done, mem_rdata,
    input  fetch_valid, fetch_rdata, cpu_stall, ld_ready,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/imem_arb_stat_cnt.sv
// rtl/imem_arb_stat_cnt.sv - saturating event counter used for stall statistics
module imem_arb_stat_cnt #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - single-port imem arbiter: LOAD fill, RUN fetch, bounded PATCH bursts
// IMEM_ARB_STATS_EN builds the stall-cycle counter; otherwise o_stall_cycles is tied to 0.
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int RUN_MIN   = DEF_RUN_MIN
) (
  input  logic         i_clk,
  input  logic         i_reset,
  imem_arbiter_if.slave bus,
  output logic [31:0]  o_stall_cycles
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int RW = $clog2(RUN_MIN + 1);
  localparam logic [BW-1:0] BURST_ONE  = BW'(1);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_BURST);
  localparam logic [RW-1:0] RUN_ONE    = RW'(1);
  localparam logic [RW-1:0] RUN_SAT    = RW'(RUN_MIN);
  // A patch may start in the RUN_MIN-th RUN cycle, so RUN_MIN cycles always separate bursts
  localparam logic [RW-1:0] RUN_GO     = RW'(RUN_MIN - 1);

  arb_state_e        r_state;
  arb_state_e        w_next_state;
  logic [BW-1:0]     r_burst_cnt;
  logic [RW-1:0]     r_run_cnt;
  logic              r_fetch_valid;
  logic [DATA_W-1:0] r_rdata_hold;

  logic              w_cpu_stall;
  logic              w_ld_ready;
  logic              w_mem_en;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic              w_fetch_grant;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_cpu_stall   = 1'b1;
    w_ld_ready    = 1'b0;
    w_mem_en      = 1'b0;
    w_mem_we      = 1'b0;
    w_mem_addr    = '0;
    w_mem_wdata   = '0;
    w_fetch_grant = 1'b0;
    case (r_state)
      LOAD: begin
        w_ld_ready = 1'b1;
        if (bus.ld_valid) begin
          w_mem_en    = 1'b1;
          w_mem_we    = 1'b1;
          w_mem_addr  = bus.ld_addr;
          w_mem_wdata = bus.ld_data;
        end
        if (bus.ld_done) w_next_state = RUN;
      end
      RUN: begin
        w_cpu_stall = 1'b0;
        if (bus.fetch_req) begin
          w_mem_en      = 1'b1;
          w_mem_addr    = bus.fetch_addr;
          w_fetch_grant = 1'b1;
        end
        if (bus.ld_valid && (r_run_cnt >= RUN_GO)) w_next_state = PATCH;
      end
      PATCH: begin
        w_ld_ready = 1'b1;
        if (bus.ld_valid) begin
          w_mem_en    = 1'b1;
          w_mem_we    = 1'b1;
          w_mem_addr  = bus.ld_addr;
          w_mem_wdata = bus.ld_data;
        end
        if (!bus.ld_valid || bus.ld_done || (r_burst_cnt == BURST_LAST)) w_next_state = RUN;
      end
      default: w_next_state = LOAD;
    endcase
    // reset must silence the memory port in the very cycle it is raised
    if (i_reset) begin
      w_cpu_stall   = 1'b1;
      w_ld_ready    = 1'b0;
      w_mem_en      = 1'b0;
      w_mem_we      = 1'b0;
      w_mem_addr    = '0;
      w_mem_wdata   = '0;
      w_fetch_grant = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_burst_cnt   <= '0;
      r_run_cnt     <= '0;
      r_fetch_valid <= 1'b0;
      r_rdata_hold  <= '0;
    end else begin
      r_fetch_valid <= w_fetch_grant;
      if (r_fetch_valid) r_rdata_hold <= bus.mem_rdata;
      if (r_state != PATCH) begin
        r_burst_cnt <= '0;
      end else if (bus.ld_valid && (r_burst_cnt != BURST_MAX)) begin
        r_burst_cnt <= r_burst_cnt + BURST_ONE;
      end
      if (r_state != RUN) begin
        r_run_cnt <= '0;
      end else if (r_run_cnt != RUN_SAT) begin
        r_run_cnt <= r_run_cnt + RUN_ONE;
      end
    end
  end

  assign bus.cpu_stall   = w_cpu_stall;
  assign bus.ld_ready    = w_ld_ready;
  assign bus.mem_en      = w_mem_en;
  assign bus.mem_we      = w_mem_we;
  assign bus.mem_addr    = w_mem_addr;
  assign bus.mem_wdata   = w_mem_wdata;
  assign bus.fetch_valid = r_fetch_valid && !i_reset;
  assign bus.fetch_rdata = i_reset ? '0 : (r_fetch_valid ? bus.mem_rdata : r_rdata_hold);

`ifdef IMEM_ARB_STATS_EN
  logic [31:0] w_stall_cnt;

  imem_arb_stat_cnt #(.W(32)) u_stat_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (w_cpu_stall),
    .o_count (w_stall_cnt)
  );

  assign o_stall_cycles = i_reset ? 32'd0 : w_stall_cnt;
`else
  assign o_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - directed self-checking bench for imem_arbiter with a behavioural imem model
module tb_imem_arbiter;

  logic        clk;
  logic        reset;
  logic [31:0] stall_cycles;

  imem_arbiter_if bus ();

  imem_arbiter dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .bus            (bus),
    .o_stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] tb_mem [0:1023];

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) tb_mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= tb_mem[bus.mem_addr];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] img [0:3];
  int j, acc1, acc2, gap, gap_bad, phase;
  logic w;

  initial begin
    img[0] = 32'h00500093;
    img[1] = 32'h00A00113;
    img[2] = 32'h002081B3;
    img[3] = 32'h0000006F;
    reset = 1'b1;
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    bus.ld_valid   = 1'b0;
    bus.ld_addr    = '0;
    bus.ld_data    = '0;
    bus.ld_done    = 1'b0;

    step(); step();
    chk("rst_stall", 32'(bus.cpu_stall), 32'd1);
    chk("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_fetch_valid", 32'(bus.fetch_valid), 32'd0);
    chk("rst_fetch_rdata", bus.fetch_rdata, 32'd0);
    chk("rst_stall_cycles", stall_cycles, 32'd0);

    reset = 1'b0;
    #1;
    chk("load_ld_ready", 32'(bus.ld_ready), 32'd1);
    chk("load_stall", 32'(bus.cpu_stall), 32'd1);

    for (int i = 0; i < 4; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_addr  = 10'(i);
      bus.ld_data  = img[i];
      bus.ld_done  = (i == 3);
      #1;
      chk("load_en_we", 32'({bus.mem_en, bus.mem_we}), 32'd3);
      chk("load_addr", 32'(bus.mem_addr), 32'(i));
      step();
    end
    bus.ld_valid = 1'b0;
    bus.ld_done  = 1'b0;
    #1;
    chk("run_stall", 32'(bus.cpu_stall), 32'd0);
    chk("run_ld_ready", 32'(bus.ld_ready), 32'd0);

    for (int k = 0; k < 4; k++) begin
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 10'(k);
      step();
      bus.fetch_req = 1'b0;
      #1;
      chk("fetch_valid", 32'(bus.fetch_valid), 32'd1);
      chk("fetch_rdata", bus.fetch_rdata, img[k]);
      step();
      chk("fetch_valid_drop", 32'(bus.fetch_valid), 32'd0);
      chk("fetch_rdata_hold", bus.fetch_rdata, img[k]);
    end

    // single-word patch while a fetch is in flight
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 10'd1;
    bus.ld_valid   = 1'b1;
    bus.ld_addr    = 10'd2;
    bus.ld_data    = 32'hDEADBEEF;
    #1;
    chk("run_no_accept", 32'(bus.ld_ready), 32'd0);
    step();
    chk("patch_stall", 32'(bus.cpu_stall), 32'd1);
    chk("patch_pending_fv", 32'(bus.fetch_valid), 32'd1);
    chk("patch_pending_rdata", bus.fetch_rdata, img[1]);
    chk("patch_we", 32'({bus.mem_en, bus.mem_we}), 32'd3);
    chk("patch_addr", 32'(bus.mem_addr), 32'd2);
    step();
    bus.ld_valid = 1'b0;
    #1;
    chk("patch_tail_stall", 32'(bus.cpu_stall), 32'd1);
    chk("patch_fetch_ignored", 32'(bus.mem_en), 32'd0);
    step();
    bus.fetch_addr = 10'd2;
    #1;
    chk("resume_stall", 32'(bus.cpu_stall), 32'd0);
    chk("no_fv_for_stalled_req", 32'(bus.fetch_valid), 32'd0);
    step();
    bus.fetch_req = 1'b0;
    #1;
    chk("patched_fv", 32'(bus.fetch_valid), 32'd1);
    chk("patched_rdata", bus.fetch_rdata, 32'hDEADBEEF);

    // 20-write stream splits into 16 + 4 with a 4-cycle RUN window between
    for (int i = 0; i < 5; i++) step();
    j = 0; acc1 = 0; acc2 = 0; gap = 0; gap_bad = 0; phase = 0;
    for (int c = 0; c < 40; c++) begin
      bus.ld_valid = (j < 20);
      bus.ld_addr  = 10'(16 + j);
      bus.ld_data  = 32'hA0000000 + 32'(j);
      #1;
      w = bus.ld_valid && bus.ld_ready;
      if (phase == 0) begin
        if (w) acc1++;
        else if (acc1 > 0) begin
          phase = 1; gap = 1;
          if (bus.cpu_stall) gap_bad++;
        end
      end else if (phase == 1) begin
        if (w) begin phase = 2; acc2 = 1; end
        else begin
          gap++;
          if (bus.cpu_stall) gap_bad++;
        end
      end else if (w) begin
        acc2++;
      end
      if (w) j++;
      step();
    end
    chk("burst1_accepted", 32'(acc1), 32'd16);
    chk("run_gap_cycles", 32'(gap), 32'd4);
    chk("run_gap_stalled", 32'(gap_bad), 32'd0);
    chk("burst2_accepted", 32'(acc2), 32'd4);
    chk("burst_first_word", tb_mem[16], 32'hA0000000);
    chk("burst_last_word", tb_mem[35], 32'hA0000013);

    // LOAD with write and ld_done in the same cycle
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 10'd5;
    bus.ld_data  = 32'h12345678;
    bus.ld_done  = 1'b1;
    #1;
    chk("load_done_we", 32'({bus.mem_en, bus.mem_we}), 32'd3);
    step();
    bus.ld_valid = 1'b0;
    bus.ld_done  = 1'b0;
    #1;
    chk("load_done_run", 32'(bus.cpu_stall), 32'd0);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 10'd5;
    step();
    bus.fetch_req = 1'b0;
    #1;
    chk("load_done_fetch", bus.fetch_rdata, 32'h12345678);

    // reset after three patch writes
    for (int i = 0; i < 4; i++) step();
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 10'd40;
    bus.ld_data  = 32'hB0000000;
    step();
    for (int k = 0; k < 3; k++) begin
      bus.ld_addr = 10'(40 + k);
      bus.ld_data = 32'hB0000000 + 32'(k);
      step();
    end
    bus.ld_addr = 10'd43;
    bus.ld_data = 32'hB0000003;
    reset = 1'b1;
    #1;
    chk("rst_mid_patch_en", 32'(bus.mem_en), 32'd0);
    chk("rst_mid_patch_stall", 32'(bus.cpu_stall), 32'd1);
    step();
    chk("rst_edge_ld_ready", 32'(bus.ld_ready), 32'd0);
    chk("rst_edge_fv", 32'(bus.fetch_valid), 32'd0);
    chk("rst_edge_rdata", bus.fetch_rdata, 32'd0);
    reset = 1'b0;
    bus.ld_valid = 1'b0;
    #1;
    chk("post_rst_ld_ready", 32'(bus.ld_ready), 32'd1);
    chk("patch_write3", tb_mem[42], 32'hB0000002);
    chk("no_write_in_reset", 32'(tb_mem[43] === 32'hB0000003), 32'd0);

`ifdef IMEM_ARB_STATS_EN
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step();
    bus.ld_done = 1'b1;
    step();
    bus.ld_done = 1'b0;
    #1;
    chk("stall_cycles_load", stall_cycles, 32'd6);
    for (int i = 0; i < 3; i++) step();
    chk("stall_cycles_run", stall_cycles, 32'd6);
`else
    chk("stall_cycles_off", stall_cycles, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
